// File: rtl/bla_sub_64bit_seq.sv
// Multi-cycle borrow-lookahead subtractor: diff = a - b - bin, one SLICE-bit slice per cycle, LSB first.
// Done pulses NSLICE+1 cycles after an accepted start; start is accepted only while ready (IDLE).
module bla_sub_64bit_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int NGRP   = SLICE / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r, b_r, diff_w, diff_full;
  logic             brw;
  logic [SLICE-1:0] a_s, b_s, g, p, s_diff;
  logic [SLICE:0]   bw;
  logic [3:0]       gg, pp;
  logic             c0;

  // Slice datapath: borrows resolved per 4-bit group, groups chained by group generate/propagate.
  always_comb begin
    a_s  = a_r[int'(k)*SLICE +: SLICE];
    b_s  = b_r[int'(k)*SLICE +: SLICE];
    g    = ~a_s & b_s;
    p    = ~(a_s ^ b_s);
    bw   = '0;
    bw[0] = brw;
    gg   = '0;
    pp   = '0;
    c0   = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      gg = g[4*j +: 4];
      pp = p[4*j +: 4];
      c0 = bw[4*j];
      bw[4*j+1] = gg[0] | (pp[0] & c0);
      bw[4*j+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
      bw[4*j+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c0);
      bw[4*j+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
                  (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c0);
    end
    s_diff    = a_s ^ b_s ^ bw[SLICE-1:0];
    diff_full = diff_w;
    diff_full[int'(k)*SLICE +: SLICE] = s_diff;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nx = S_RUN;
      end
      S_RUN: begin
        if (k == KLAST) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      a_r    <= '0;
      b_r    <= '0;
      brw    <= 1'b0;
      diff_w <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            brw <= bin;
            k   <= '0;
          end
        end
        S_RUN: begin
          diff_w <= diff_full;
          brw    <= bw[SLICE];
          k      <= k + KW'(1);
          // Result flags only move on the edge into DONE; they hold through the next RUN.
          if (k == KLAST) begin
            diff <= diff_full;
            bout <= bw[SLICE];
            ovf  <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (diff_full[WIDTH-1] ^ a_r[WIDTH-1]);
            zero <= ~|diff_full;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bla_sub_64bit_seq.sv
// Scoreboard bench for bla_sub_64bit_seq: expectations queued at issue, checked at each done pulse.
module tb_bla_sub_64bit_seq;
  logic        clk = 1'b0;
  logic        rst, start, bin, ready, done, bout, ovf, zero;
  logic [63:0] a, b, diff;
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  res_t sb[$];

  always #5 clk = ~clk;

  bla_sub_64bit_seq #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [63:0] x, input logic [63:0] y, input logic c);
    logic [64:0] t;
    res_t r;
    t    = {1'b0, x} - {1'b0, y} - {64'd0, c};
    r.d  = t[63:0];
    r.bo = t[64];
    r.ov = (x[63] ^ y[63]) & (t[63] ^ x[63]);
    r.z  = (t[63:0] == 64'd0);
    return r;
  endfunction

  // Drives one accepted start (waiting for ready), queues its expectation, then scrambles the inputs.
  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic c, input res_t exp);
    for (int i = 0; i < 10 && ready !== 1'b1; i++) @(negedge clk);
    start = 1'b1; a = x; b = y; bin = c;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    bin = 1'($urandom_range(0, 1));
  endtask

  // Counts negedges until done; lat = -1 on timeout. held drops if diff moves before done.
  task automatic wait_done(output int lat, output bit held);
    logic [63:0] d0;
    d0   = diff;
    held = 1'b1;
    lat  = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (diff !== d0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("FAIL reset_hs got=%b want=10", {ready, done});
    end
    total++;
    if ({diff, bout, ovf, zero} !== 67'd0) begin
      bad++; $display("FAIL reset_out got=%h want=0", {diff, bout, ovf, zero});
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [63:0] va[7], vb[7];
    logic        vc[7];
    res_t        ve[7];
    res_t        got, exp;
    int          lat;
    bit          held;
    va[0] = 64'd5;                 vb[0] = 64'd3;                 vc[0] = 1'b0; ve[0] = {64'd2, 3'b000};
    va[1] = 64'd0;                 vb[1] = 64'd1;                 vc[1] = 1'b0; ve[1] = {64'hFFFF_FFFF_FFFF_FFFF, 3'b100};
    va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'd1;               vc[2] = 1'b0; ve[2] = {64'h7FFF_FFFF_FFFF_FFFF, 3'b010};
    va[3] = 64'h1234_5678_9ABC_DEF0; vb[3] = 64'h1234_5678_9ABC_DEF0; vc[3] = 1'b0; ve[3] = {64'd0, 3'b001};
    va[4] = 64'h1234_5678_9ABC_DEF0; vb[4] = 64'h1234_5678_9ABC_DEF0; vc[4] = 1'b1; ve[4] = {64'hFFFF_FFFF_FFFF_FFFF, 3'b100};
    va[5] = 64'h0001_0000_0000_0000; vb[5] = 64'd1;               vc[5] = 1'b0; ve[5] = {64'h0000_FFFF_FFFF_FFFF, 3'b000};
    va[6] = 64'd0;                 vb[6] = 64'h8000_0000_0000_0000; vc[6] = 1'b0; ve[6] = {64'h8000_0000_0000_0000, 3'b110};
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], vc[i], ve[i]);
      wait_done(lat, held);
      total++;
      if (lat != 5) begin
        bad++; $display("FAIL vec%0d latency got=%0d want=5", i, lat);
      end
      total++;
      if (held !== 1'b1) begin
        bad++; $display("FAIL vec%0d held got=%0d want=1", i, held);
      end
      exp = sb.pop_front();
      got = {diff, bout, ovf, zero};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL vec%0d result got=%h want=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] x1, y1, x2, y2;
    res_t        got, exp;
    int          lat;
    bit          held;
    x1 = {$urandom, $urandom}; y1 = {$urandom, $urandom};
    x2 = {$urandom, $urandom}; y2 = {$urandom, $urandom};
    for (int i = 0; i < 10 && ready !== 1'b1; i++) @(negedge clk);
    start = 1'b1; a = x1; b = y1; bin = 1'b0;
    sb.push_back(model(x1, y1, 1'b0));
    @(posedge clk);
    #1;
    a = x2; b = y2; bin = 1'b1;
    sb.push_back(model(x2, y2, 1'b1));
    wait_done(lat, held);
    exp = sb.pop_front();
    got = {diff, bout, ovf, zero};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL b2b_first got=%h want=%h", got, exp);
    end
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL b2b_idle ready got=%b want=1", ready);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, held);
    total++;
    if (lat != 5) begin
      bad++; $display("FAIL b2b_latency got=%0d want=5", lat);
    end
    exp = sb.pop_front();
    got = {diff, bout, ovf, zero};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", got, exp);
    end
  endtask

  task automatic test_ignore_start();
    res_t got, exp;
    int   lat, pulses;
    bit   held;
    issue(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0,
          model(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0));
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL ign_ready got=%b want=0", ready);
    end
    start = 1'b1; a = 64'd1; b = 64'd2; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, held);
    total++;
    if (lat != 3) begin
      bad++; $display("FAIL ign_latency got=%0d want=3", lat);
    end
    exp = sb.pop_front();
    got = {diff, bout, ovf, zero};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL ign_result got=%h want=%h", got, exp);
    end
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL ign_extra_done got=%0d want=0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    issue(64'd7, 64'd9, 1'b0, model(64'd7, 64'd9, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("FAIL rstmid_hs got=%b want=10", {ready, done});
    end
    total++;
    if ({diff, bout, ovf, zero} !== 67'd0) begin
      bad++; $display("FAIL rstmid_out got=%h want=0", {diff, bout, ovf, zero});
    end
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL rstmid_done got=%0d want=0", pulses);
    end
  endtask

  task automatic test_random();
    logic [63:0] x, y;
    logic        c;
    res_t        got, exp;
    int          lat;
    bit          held;
    for (int i = 0; i < 24; i++) begin
      x = {$urandom, $urandom};
      y = (i % 4 == 0) ? x + 64'(i % 3) : {$urandom, $urandom};
      c = 1'($urandom_range(0, 1));
      issue(x, y, c, model(x, y, c));
      wait_done(lat, held);
      exp = sb.pop_front();
      got = {diff, bout, ovf, zero};
      total++;
      if (got !== exp || lat != 5) begin
        bad++; $display("FAIL rand%0d got=%h lat=%0d want=%h lat=5", i, got, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
